// File: rtl/sm4_round_iter_pkg.sv
// Shared configuration for the iterative SM4 round engine: widths, round
// count, default T-transform latency, FSM state encodings and the
// round-key index helper.
package sm4_round_iter_pkg;

    localparam int WORD_WIDTH    = 32;
    localparam int BLOCK_WIDTH   = 128;
    localparam int ROUNDS        = 32;
    localparam int T_LATENCY_DEF = 2;
    localparam int RK_IDX_W      = 5;

    // FSM state encodings
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ROUND = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    typedef logic [WORD_WIDTH-1:0]  word_t;
    typedef logic [BLOCK_WIDTH-1:0] block_t;

    // Decryption walks the key schedule backwards.
    function automatic logic [RK_IDX_W-1:0] rk_index(input logic decrypt,
                                                     input logic [RK_IDX_W-1:0] rnd);
        return decrypt ? (RK_IDX_W'(ROUNDS - 1) - rnd) : rnd;
    endfunction

endpackage

// File: rtl/sm4_round_iter_if.sv
// Bus bundle between the SM4 round engine and its parent core: block
// in/out handshakes, key-schedule lookup, T-transform hookup and debug state.
//
// Handshake semantics (both in_* and out_* channels): a transfer happens at
// the rising clock edge where valid && ready are both high; the producer
// holds valid and its payload stable until that edge, and valid must not
// depend combinationally on ready.
interface sm4_round_iter_if;
    import sm4_round_iter_pkg::*;

    logic                in_valid;
    logic                in_ready;
    block_t              in_block;
    logic                in_decrypt;
    logic [RK_IDX_W-1:0] rk_idx;
    word_t               rk_in;
    word_t               t_in;
    word_t               t_out;
    logic                t_stall;
    logic                out_valid;
    logic                out_ready;
    block_t              out_block;
    logic                busy;
    logic [1:0]          dbg_state;

    // Parent core / environment side
    modport master (
        output in_valid, in_block, in_decrypt, rk_in, t_out, out_ready,
        input  in_ready, rk_idx, t_in, t_stall, out_valid, out_block, busy, dbg_state
    );

    // Round engine side
    modport slave (
        input  in_valid, in_block, in_decrypt, rk_in, t_out, out_ready,
        output in_ready, rk_idx, t_in, t_stall, out_valid, out_block, busy, dbg_state
    );

endinterface

// File: rtl/sm4_round_iter.sv
// Iterative SM4 round engine. Holds the 4-word state, feeds X1^X2^X3^rk to
// the external T-transform, waits T_LATENCY+1 cycles per round so the T
// pipeline is flushed, then folds T's result into the shift register.
// After 32 rounds the reversed state is presented until accepted.
module sm4_round_iter
    import sm4_round_iter_pkg::*;
#(
    parameter int T_LATENCY = T_LATENCY_DEF
) (
    input  logic             clk,
    input  logic             rst,
    sm4_round_iter_if.slave  eng
);

    localparam int                  CNT_W    = (T_LATENCY < 1) ? 1 : $clog2(T_LATENCY + 1);
    localparam logic [CNT_W-1:0]    CNT_LAST = CNT_W'(T_LATENCY);
    localparam logic [RK_IDX_W-1:0] RND_LAST = RK_IDX_W'(ROUNDS - 1);

    logic [1:0]          state_q, state_d;
    word_t               x0_q, x1_q, x2_q, x3_q;
    word_t               x0_d, x1_d, x2_d, x3_d;
    logic [RK_IDX_W-1:0] rnd_q, rnd_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                mode_q, mode_d;
    logic                in_round;
    logic                in_done;

    assign in_round = (state_q == ST_ROUND);
    assign in_done  = (state_q == ST_DONE);

    // Outputs are decoded from registered state only, so an async reset
    // forces them to their idle values immediately.
    assign eng.in_ready  = (state_q == ST_IDLE);
    assign eng.busy      = (state_q != ST_IDLE);
    assign eng.out_valid = in_done;
    assign eng.out_block = in_done ? {x3_q, x2_q, x1_q, x0_q} : '0;
    assign eng.t_stall   = !in_round;
    assign eng.rk_idx    = in_round ? rk_index(mode_q, rnd_q) : '0;
    assign eng.t_in      = in_round ? (x1_q ^ x2_q ^ x3_q ^ eng.rk_in) : '0;
    assign eng.dbg_state = state_q;

    // Next-state logic: accept, round stepping and output release
    always_comb begin
        state_d = state_q;
        x0_d    = x0_q;
        x1_d    = x1_q;
        x2_d    = x2_q;
        x3_d    = x3_q;
        rnd_d   = rnd_q;
        cnt_d   = cnt_q;
        mode_d  = mode_q;
        case (state_q)
            ST_IDLE: begin
                if (eng.in_valid) begin
                    x0_d    = eng.in_block[127:96];
                    x1_d    = eng.in_block[95:64];
                    x2_d    = eng.in_block[63:32];
                    x3_d    = eng.in_block[31:0];
                    mode_d  = eng.in_decrypt;
                    rnd_d   = '0;
                    cnt_d   = '0;
                    state_d = ST_ROUND;
                end
            end
            ST_ROUND: begin
                if (cnt_q == CNT_LAST) begin
                    // T output now corresponds to this round's t_in
                    x0_d  = x1_q;
                    x1_d  = x2_q;
                    x2_d  = x3_q;
                    x3_d  = x0_q ^ eng.t_out;
                    cnt_d = '0;
                    if (rnd_q == RND_LAST) begin
                        rnd_d   = '0;
                        state_d = ST_DONE;
                    end else begin
                        rnd_d = rnd_q + RK_IDX_W'(1);
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_DONE: begin
                if (eng.out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State registers with asynchronous reset discarding any in-flight block
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            x0_q    <= '0;
            x1_q    <= '0;
            x2_q    <= '0;
            x3_q    <= '0;
            rnd_q   <= '0;
            cnt_q   <= '0;
            mode_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            x0_q    <= x0_d;
            x1_q    <= x1_d;
            x2_q    <= x2_d;
            x3_q    <= x3_d;
            rnd_q   <= rnd_d;
            cnt_q   <= cnt_d;
            mode_q  <= mode_d;
        end
    end

endmodule

// File: tb/tb_sm4_round_iter.sv
// Bench for sm4_round_iter: two engines (T_LATENCY=2 and 0), each with a
// T-transform model and key-schedule store built from the SM4 reference
// algorithm, directed vectors, and a scoreboard monitor on the output port.
module tb_sm4_round_iter;

    localparam logic [127:0] PT   = 128'h0123456789abcdeffedcba9876543210;
    localparam logic [127:0] CT   = 128'h681edf34d206965e86b3e94f536e4246;
    localparam logic [127:0] JUNK = 128'hdeadbeefcafef00d0badc0de55aa33cc;

    localparam logic [127:0] SBOX_ROWS [16] = '{
        128'hd690e9fecce13db716b614c228fb2c05,
        128'h2b679a762abe04c3aa44132649860699,
        128'h9c4250f491ef987a33540b43edcfac62,
        128'he4b31ca9c908e89580df94fa758f3fa6,
        128'h4707a7fcf37317ba83593c19e6854fa8,
        128'h686b81b27164da8bf8eb0f4b70569d35,
        128'h1e240e5e6358d1a225227c3b01217887,
        128'hd40046579fd327524c3602e7a0c4c89e,
        128'heabf8ad240c738b5a3f7f2cef96115a1,
        128'he0ae5da49b341a55ad933230f58cb1e3,
        128'h1df6e22e8266ca60c02923ab0d534e6f,
        128'hd5db3745defd8e2f03ff6a726d6c5b51,
        128'h8d1baf92bbddbc7f11d95c411f105ad8,
        128'h0ac13188a5cd7bbd2d74d012b8e5b4b0,
        128'h8969974a0c96777e65b9f109c56ec684,
        128'h18f07dec3adc4d2079ee5f3ed7cb3948
    };

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- SM4 reference functions ----------------
    function automatic logic [31:0] rol(input logic [31:0] x, input int n);
        return (x << n) | (x >> (32 - n));
    endfunction

    function automatic logic [31:0] tau(input logic [31:0] a);
        logic [31:0]  r;
        logic [127:0] row;
        logic [7:0]   b;
        r = '0;
        for (int i = 0; i < 4; i++) begin
            b   = a[8*i +: 8];
            row = SBOX_ROWS[b[7:4]];
            r[8*i +: 8] = row[127 - 8*b[3:0] -: 8];
        end
        return r;
    endfunction

    function automatic logic [31:0] t_enc(input logic [31:0] x);
        logic [31:0] b;
        b = tau(x);
        return b ^ rol(b, 2) ^ rol(b, 10) ^ rol(b, 18) ^ rol(b, 24);
    endfunction

    function automatic logic [31:0] t_key(input logic [31:0] x);
        logic [31:0] b;
        b = tau(x);
        return b ^ rol(b, 13) ^ rol(b, 23);
    endfunction

    logic [31:0] rk [32];

    // ---------------- DUTs and their environment ----------------
    sm4_round_iter_if a_if ();
    sm4_round_iter_if b_if ();

    sm4_round_iter #(.T_LATENCY(2)) dut_a (.clk(clk), .rst(rst), .eng(a_if));
    sm4_round_iter #(.T_LATENCY(0)) dut_b (.clk(clk), .rst(rst), .eng(b_if));

    logic         sel;
    logic         in_valid;
    logic [127:0] in_block;
    logic         in_decrypt;
    logic         out_ready;

    assign a_if.in_valid   = in_valid && !sel;
    assign a_if.in_block   = in_block;
    assign a_if.in_decrypt = in_decrypt;
    assign a_if.out_ready  = out_ready;
    assign a_if.rk_in      = rk[a_if.rk_idx];
    assign b_if.in_valid   = in_valid && sel;
    assign b_if.in_block   = in_block;
    assign b_if.in_decrypt = in_decrypt;
    assign b_if.out_ready  = out_ready;
    assign b_if.rk_in      = rk[b_if.rk_idx];

    // two-stage T pipeline for engine A, frozen while stalled
    logic [31:0] ta_s1, ta_s2;
    always @(posedge clk) begin
        if (!a_if.t_stall) begin
            ta_s1 <= t_enc(a_if.t_in);
            ta_s2 <= ta_s1;
        end
    end
    assign a_if.t_out = ta_s2;
    assign b_if.t_out = t_enc(b_if.t_in);

    wire         in_ready_m  = sel ? b_if.in_ready  : a_if.in_ready;
    wire         out_valid_m = sel ? b_if.out_valid : a_if.out_valid;
    wire [127:0] out_block_m = sel ? b_if.out_block : a_if.out_block;
    wire         busy_m      = sel ? b_if.busy      : a_if.busy;
    wire [4:0]   rk_idx_m    = sel ? b_if.rk_idx    : a_if.rk_idx;
    wire [31:0]  t_in_m      = sel ? b_if.t_in      : a_if.t_in;
    wire         t_stall_m   = sel ? b_if.t_stall   : a_if.t_stall;
    wire [1:0]   state_m     = sel ? b_if.dbg_state : a_if.dbg_state;

    // ---------------- scoreboard ----------------
    logic [127:0] exp_q [$];
    int n_vec = 0;
    int n_err = 0;
    int acc_cyc = 0;
    int hs_cyc = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // monitor: pops on every output handshake
    always @(negedge clk) begin
        if (!rst && out_valid_m && out_ready) begin
            hs_cyc = cyc + 1;
            if (exp_q.size() == 0) begin
                chk("unexpected_output", out_block_m, 128'h0);
            end else begin
                chk("out_block", out_block_m, exp_q.pop_front());
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic send(input logic [127:0] blk, input logic dec, input logic [127:0] exp);
        int n;
        n = 0;
        in_block   = blk;
        in_decrypt = dec;
        in_valid   = 1'b1;
        @(negedge clk);
        while (!in_ready_m && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready_m) begin
            chk("accept_timeout", in_ready_m, 1);
            in_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        acc_cyc = cyc;
        exp_q.push_back(exp);
        in_valid = 1'b0;
    endtask

    task automatic wait_valid(input int exp_lat);
        int n;
        n = 0;
        while (!out_valid_m && n < 400) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("out_valid_seen", out_valid_m, 1);
        chk("latency", cyc - acc_cyc, exp_lat);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (!in_ready_m && n < 400) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("back_to_idle", in_ready_m, 1);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_in_ready"},  in_ready_m,  1);
        chk({tag, "_out_valid"}, out_valid_m, 0);
        chk({tag, "_busy"},      busy_m,      0);
        chk({tag, "_out_block"}, out_block_m, 0);
        chk({tag, "_rk_idx"},    rk_idx_m,    0);
        chk({tag, "_t_in"},      t_in_m,      0);
        chk({tag, "_t_stall"},   t_stall_m,   1);
        chk({tag, "_state"},     state_m,     0);
    endtask

    // watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        logic [31:0] k [4];
        logic [31:0] ck, knew, x4;
        int lat;

        rst = 1'b1; sel = 1'b0; in_valid = 1'b0; in_block = '0;
        in_decrypt = 1'b0; out_ready = 1'b1;

        // key schedule for MK = PT
        k[0] = PT[127:96] ^ 32'ha3b1bac6;
        k[1] = PT[95:64]  ^ 32'h56aa3350;
        k[2] = PT[63:32]  ^ 32'h677d9197;
        k[3] = PT[31:0]   ^ 32'hb27022dc;
        for (int i = 0; i < 32; i++) begin
            ck = {8'((4*i) * 7), 8'((4*i + 1) * 7), 8'((4*i + 2) * 7), 8'((4*i + 3) * 7)};
            knew = k[0] ^ t_key(k[1] ^ k[2] ^ k[3] ^ ck);
            rk[i] = knew;
            k[0] = k[1]; k[1] = k[2]; k[2] = k[3]; k[3] = knew;
        end
        chk("rk0", rk[0], 32'hf12186f9);
        chk("rk31", rk[31], 32'h9124a012);

        repeat (2) @(posedge clk);
        #1;
        chk_reset_vals("por");
        rst = 1'b0;

        // 1: encrypt, first-round visibility, latency
        send(PT, 1'b0, CT);
        chk("rk_idx_r0", rk_idx_m, 0);
        chk("t_in_r0", t_in_m, 32'h89abcdef ^ 32'hfedcba98 ^ 32'h76543210 ^ rk[0]);
        chk("busy_round", busy_m, 1);
        chk("in_ready_round", in_ready_m, 0);
        chk("t_stall_round", t_stall_m, 0);
        repeat (3) @(posedge clk);
        #1;
        chk("rk_idx_r1", rk_idx_m, 1);
        x4 = t_in_m ^ 32'hfedcba98 ^ 32'h76543210 ^ rk[1];
        chk("x4_after_r0", x4, 32'h27fad345);
        wait_valid(96);
        wait_idle();

        // 2: decrypt, key index walks 31..0
        send(CT, 1'b1, PT);
        for (int r = 0; r < 32; r++) begin
            chk("rk_idx_dec", rk_idx_m, 31 - r);
            repeat (3) @(posedge clk);
            #1;
        end
        wait_valid(96);
        wait_idle();

        // 3: backpressure holds the result
        out_ready = 1'b0;
        send(PT, 1'b0, CT);
        wait_valid(96);
        for (int i = 0; i < 20; i++) begin
            chk("bp_out_valid", out_valid_m, 1);
            chk("bp_in_ready", in_ready_m, 0);
            chk("bp_out_block", out_block_m, CT);
            chk("bp_t_stall", t_stall_m, 1);
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("release_out_valid", out_valid_m, 0);
        chk("release_in_ready", in_ready_m, 1);

        // 4: in_valid during ROUND is ignored
        send(PT, 1'b0, CT);
        repeat (10) @(posedge clk);
        #1;
        in_block = JUNK;
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            chk("busy_in_ready", in_ready_m, 0);
        end
        in_valid = 1'b0;
        wait_valid(96);
        wait_idle();

        // 5: async reset at round 10, then a clean run
        send(PT, 1'b0, CT);
        repeat (30) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        chk_reset_vals("midrst");
        exp_q.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        send(PT, 1'b0, CT);
        wait_valid(96);
        wait_idle();

        // 6: back-to-back blocks on both engines
        for (int s = 0; s < 2; s++) begin
            sel = (s == 1);
            lat = (s == 1) ? 32 : 96;
            send(PT, 1'b0, CT);
            wait_valid(lat);
            send(CT, 1'b1, PT);
            chk("b2b_accept_cycle", acc_cyc, hs_cyc + 1);
            wait_valid(lat);
            wait_idle();
        end

        repeat (5) @(posedge clk);
        chk("queue_drained", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/sm4_round_iter.md
Name: sm4_round_iter

Overview:
- Iterative SM4 round engine for encrypt and decrypt.
- Sits directly upstream and downstream of the T-transform stage (tau then L):
  - forms the T input X1^X2^X3^rk;
  - consumes the T output;
  - computes X(i+4) = X(i) ^ T(...).
- Runs 32 rounds per 128-bit block, then emits the reversed final state.
- Sequences the round-key index for the key-schedule store and handshakes blocks in and out.

Parameters:
- WORD_WIDTH, 32, SM4 word width.
- BLOCK_WIDTH, 128, block width (4 words).
- ROUNDS, 32, rounds per block.
- T_LATENCY, 2, register stages inside the attached T-transform (0 = combinational).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  input block valid.
- in_ready  out  1  engine can accept a block.
- in_block  in  128  {X0,X1,X2,X3}, X0 in bits 127:96.
- in_decrypt  in  1  1 = decrypt (reverse key order); sampled on accept.
- rk_idx  out  5  round-key index requested this round.
- rk_in  in  32  round key for rk_idx, valid combinationally in the same cycle.
- t_in  out  32  T-transform input.
- t_out  in  32  T-transform output.
- t_stall  out  1  stall to the T-transform pipeline.
- out_valid  out  1  result block valid.
- out_ready  in  1  downstream accepts result.
- out_block  out  128  {X35,X34,X33,X32}.
- busy  out  1  high in ROUND or DONE.

Behaviour:
- Reset values (async, takes effect immediately, also mid-operation): state=IDLE, in_ready=1, out_valid=0, busy=0, out_block=0, rk_idx=0, t_in=0, t_stall=1, round counter=0, wait counter=0, mode=0. Any in-flight block is discarded.
- FSM states: IDLE, ROUND, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready at a clock edge: load state regs X0..X3 from in_block, latch mode, rnd=0, cnt=0, go to ROUND.
- ROUND:
  - in_ready=0, t_stall=0.
  - rk_idx = mode ? 31-rnd : rnd.
  - t_in = X1^X2^X3^rk_in, held stable for the whole round.
  - cnt counts 0..T_LATENCY.
  - At the edge where cnt==T_LATENCY: shift X0<=X1, X1<=X2, X2<=X3, X3<=X0^t_out; cnt<=0; rnd<=rnd+1.
  - If rnd==ROUNDS-1 at that edge, go to DONE instead.
  - Round period is T_LATENCY+1 cycles, which flushes the T pipeline with no tagging.
- DONE:
  - out_valid=1, out_block={X3,X2,X1,X0} (the reversal R).
  - t_stall=1, so the T pipeline is frozen outside ROUND.
  - Output is held stable while out_ready=0.
  - On out_valid&&out_ready: go to IDLE; out_valid drops next cycle and in_ready rises next cycle.
  - No accept occurs in the same cycle as DONE.
- Latency: with accept at edge E, out_valid is high from edge E+ROUNDS*(T_LATENCY+1) (96 cycles for T_LATENCY=2, 32 for T_LATENCY=0). Latency is independent of mode.
- The round counter wraps only via the DONE transition; rnd never exceeds 31.
- in_valid while not in_ready: ignored; in_block is not sampled.
- in_decrypt changing mid-block: no effect.

Decomposition:
- Shared config header holds WORD_WIDTH, BLOCK_WIDTH, ROUNDS, T_LATENCY default and the FSM state encodings (IDLE=2'd0, ROUND=2'd1, DONE=2'd2).
- No sub-module is required. The T-transform is instantiated beside this block by the parent core, which wires t_in/t_out/t_stall.
- The 4-word shift register is kept inline.

Test Plan:
1. Encrypt, T_LATENCY=2.
   - Stimulus: in_block=0123456789abcdeffedcba9876543210, keys from MK=0123456789abcdeffedcba9876543210 (rk0=f12186f9, rk31=9124a012).
   - Required: rk_idx=0 first, X3 after round 0 = 27fad345, out_block=681edf34d206965e86b3e94f536e4246, out_valid at accept+96.
2. Decrypt.
   - Stimulus: in_block=681edf34d206965e86b3e94f536e4246, in_decrypt=1.
   - Required: rk_idx sequence 31..0, out_block=0123456789abcdeffedcba9876543210.
3. Backpressure.
   - Stimulus: out_ready=0 for 20 cycles after out_valid.
   - Required: out_block stable, in_ready=0; one cycle after out_ready=1, out_valid=0 and in_ready=1.
4. Input ignored when busy.
   - Stimulus: in_valid pulsed with a different block during ROUND.
   - Required: no effect; result still matches vector 1.
5. Mid-operation reset.
   - Stimulus: rst asserted at round 10, asynchronous to clk.
   - Required: outputs go immediately to reset values; a following vector-1 run completes correctly.
6. Back-to-back blocks.
   - Stimulus: two blocks with out_ready=1; repeat with T_LATENCY=0.
   - Required: both results correct; second accept at the first cycle in_ready=1; T_LATENCY=0 latency is 32 cycles.
